// File: rtl/window_scan_ctrl_pkg.sv
// Shared definitions for the 3x3 neighbourhood filter blocks: controller state
// encoding, kernel size and the default frame geometry.
package window_pkg;

    localparam int KSIZE     = 3;
    localparam int DEF_IMG_W = 30;
    localparam int DEF_IMG_H = 30;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STREAM,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/window_scan_ctrl_if.sv
// Handshake and output bundle between the window scan controller (slave side)
// and the pixel source / window datapath (master side).
interface window_scan_ctrl_if
    import window_pkg::*;
#(
    parameter int CW = $clog2(DEF_IMG_W),
    parameter int RW = $clog2(DEF_IMG_H)
);
    logic          done_i;
    logic          in_ready_o;
    logic          shift_en_o;
    logic          flush_o;
    logic          out_valid_o;
    logic [RW-1:0] out_row_o;
    logic [CW-1:0] out_col_o;
    logic          pad_top_o;
    logic          pad_bot_o;
    logic          pad_left_o;
    logic          pad_right_o;
    logic          frame_done_o;
    logic          busy_o;

    modport slave (
        input  done_i,
        output in_ready_o, shift_en_o, flush_o, out_valid_o, out_row_o, out_col_o,
        output pad_top_o, pad_bot_o, pad_left_o, pad_right_o, frame_done_o, busy_o
    );

    modport master (
        output done_i,
        input  in_ready_o, shift_en_o, flush_o, out_valid_o, out_row_o, out_col_o,
        input  pad_top_o, pad_bot_o, pad_left_o, pad_right_o, frame_done_o, busy_o
    );
endinterface

// File: rtl/window_scan_ctrl_raster_counter.sv
// Raster-order column/row position counter: column wraps at W-1 into the next
// row, row wraps at H-1 back to zero; last_o flags the final position.
module raster_counter
    import window_pkg::*;
#(
    parameter int W  = DEF_IMG_W,
    parameter int H  = DEF_IMG_H,
    parameter int CW = $clog2(W),
    parameter int RW = $clog2(H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          last_o
);
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_last;
    logic          row_last;

    assign col_last = (col_q == CW'(W - 1));
    assign row_last = (row_q == RW'(H - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (en_i) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = col_last & row_last;
endmodule

// File: rtl/window_scan_ctrl.sv
// Sequencer for the streaming 3x3 window datapath: tracks input and output raster
// positions, drives buffer shifts, flushes the last row/column and flags padding.
module window_scan_ctrl
    import window_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    window_scan_ctrl_if.slave bus
);
    state_t        state_q, state_d;
    logic          rdy_q, rdy_d;
    logic          accept;
    logic          produce;
    logic          fill_end;
    logic [CW-1:0] in_col, out_col;
    logic [RW-1:0] in_row, out_row;
    logic          in_last, out_last;

    logic          out_valid_q, out_valid_d;
    logic [RW-1:0] out_row_q, out_row_d;
    logic [CW-1:0] out_col_q, out_col_d;
    logic          pad_top_q, pad_top_d;
    logic          pad_bot_q, pad_bot_d;
    logic          pad_left_q, pad_left_d;
    logic          pad_right_q, pad_right_d;

    raster_counter #(.W(IMG_W), .H(IMG_H), .CW(CW), .RW(RW)) u_in_pos (
        .clk(clk), .rst(rst_n), .en_i(accept),
        .col_o(in_col), .row_o(in_row), .last_o(in_last)
    );

    raster_counter #(.W(IMG_W), .H(IMG_H), .CW(CW), .RW(RW)) u_out_pos (
        .clk(clk), .rst(rst_n), .en_i(produce),
        .col_o(out_col), .row_o(out_row), .last_o(out_last)
    );

    // Input index IMG_W+1 sits at raster position (1,1); it completes the first window.
    assign fill_end = (in_row == RW'(1)) && (in_col == CW'(1));
    assign accept   = bus.in_ready_o & bus.done_i;
    assign produce  = ((state_q == STREAM) & accept)
                    | ((state_q == FILL) & accept & fill_end)
                    | (state_q == FLUSH);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdy_d   = 1'b1;
        unique case (state_q)
            IDLE:    if (accept) state_d = FILL;
            FILL:    if (accept && fill_end) state_d = STREAM;
            STREAM:  if (accept && in_last) state_d = FLUSH;
            FLUSH:   if (out_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready_o   = rdy_q & ((state_q == IDLE) | (state_q == FILL) | (state_q == STREAM));
        bus.flush_o      = (state_q == FLUSH);
        bus.shift_en_o   = (rdy_q & bus.done_i & ((state_q == IDLE) | (state_q == FILL) | (state_q == STREAM)))
                         | (state_q == FLUSH);
        bus.frame_done_o = (state_q == DONE);
        bus.busy_o       = (state_q != IDLE);
    end

    // Coordinates and flags are zeroed whenever no window completes this cycle.
    always_comb begin
        out_valid_d = produce;
        out_row_d   = produce ? out_row : '0;
        out_col_d   = produce ? out_col : '0;
        pad_top_d   = produce & (out_row == '0);
        pad_bot_d   = produce & (out_row == RW'(IMG_H - 1));
        pad_left_d  = produce & (out_col == '0);
        pad_right_d = produce & (out_col == CW'(IMG_W - 1));
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            pad_top_q   <= 1'b0;
            pad_bot_q   <= 1'b0;
            pad_left_q  <= 1'b0;
            pad_right_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            pad_top_q   <= pad_top_d;
            pad_bot_q   <= pad_bot_d;
            pad_left_q  <= pad_left_d;
            pad_right_q <= pad_right_d;
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.out_row_o   = out_row_q;
    assign bus.out_col_o   = out_col_q;
    assign bus.pad_top_o   = pad_top_q;
    assign bus.pad_bot_o   = pad_bot_q;
    assign bus.pad_left_o  = pad_left_q;
    assign bus.pad_right_o = pad_right_q;
endmodule
